// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage, the instruction memory, the hazard/branch
// logic and the decode stage. The fetch stage uses the master modport.
interface instruction_fetch_if;
  logic        MemConflict;
  logic        stall_i;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
  logic [15:0] fetch_count;

  modport master (
    input  MemConflict,
    input  stall_i,
    input  branch_valid,
    input  branch_target,
    input  imem_instr,
    output imem_pc,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid,
    output fetch_state,
    output fetch_count
  );

  modport slave (
    output MemConflict,
    output stall_i,
    output branch_valid,
    output branch_target,
    output imem_instr,
    input  imem_pc,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid,
    input  fetch_state,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads a zero-latency instruction memory and loads
// the IF/ID register, handling memory conflicts, decode stalls and branch redirects.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd4,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StConflict = 2'b01,
    StFlushed  = 2'b10,
    StIllegal  = 2'b11
  } state_e;

  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_if_pc;
  logic        r_valid;
  logic [15:0] r_count;
  state_e      r_state;

  logic [15:0] w_pc_d;
  logic [15:0] w_instr_d;
  logic [15:0] w_if_pc_d;
  logic        w_valid_d;
  logic [15:0] w_count_d;
  state_e      w_state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
      r_if_pc <= 16'h0000;
      r_valid <= 1'b0;
      r_count <= 16'h0000;
      r_state <= StRun;
    end else begin
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_if_pc <= w_if_pc_d;
      r_valid <= w_valid_d;
      r_count <= w_count_d;
      r_state <= w_state_d;
    end
  end

  // The next state depends only on this cycle's events; the current state is purely
  // reported, so an illegal encoding falls back to a valid one on the next edge.
  always_comb begin
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_if_pc_d = r_if_pc;
    w_valid_d = r_valid;
    w_count_d = r_count;
    w_state_d = StRun;

    if (bus.branch_valid) begin
      w_pc_d    = bus.branch_target;
      w_instr_d = NOP_WORD;
      w_if_pc_d = 16'h0000;
      w_valid_d = 1'b0;
      w_state_d = bus.MemConflict ? StConflict : StFlushed;
    end else if (bus.MemConflict) begin
      // With decode stalled, IF/ID keeps its instruction instead of taking a bubble.
      if (!bus.stall_i) begin
        w_instr_d = NOP_WORD;
        w_if_pc_d = 16'h0000;
        w_valid_d = 1'b0;
      end
      w_state_d = StConflict;
    end else if (bus.stall_i) begin
      w_state_d = StRun;
    end else begin
      w_instr_d = bus.imem_instr;
      w_if_pc_d = r_pc;
      w_valid_d = 1'b1;
      w_pc_d    = r_pc + PC_STEP;
      w_count_d = r_count + 16'd1;
      w_state_d = StRun;
    end
  end

  assign bus.imem_pc     = r_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc    = r_if_pc;
  assign bus.if_id_valid = r_valid;
  assign bus.fetch_count = r_count;
  assign bus.fetch_state = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a rule-level model checked every cycle plus
// hand-computed literal expectations for the main scenarios and the PC wrap.
module tb_instruction_fetch;
  localparam logic [15:0] Nop = 16'h0800;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  instruction_fetch_if bus ();
  instruction_fetch_if wbus ();

  instruction_fetch #(
    .RESET_PC(16'h0000),
    .PC_STEP (16'd4),
    .NOP_WORD(16'h0800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  instruction_fetch #(
    .RESET_PC(16'hFFFC),
    .PC_STEP (16'd4),
    .NOP_WORD(16'h0800)
  ) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(wbus.master)
  );

  // Instruction memory holds its own word index as data.
  function automatic logic [15:0] mem(input logic [15:0] a);
    return a >> 2;
  endfunction

  assign bus.imem_instr     = mem(bus.imem_pc);
  assign wbus.imem_instr    = mem(wbus.imem_pc);
  assign wbus.MemConflict   = 1'b0;
  assign wbus.stall_i       = 1'b0;
  assign wbus.branch_valid  = 1'b0;
  assign wbus.branch_target = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline contents as the rules define them.
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_instr = Nop;
  logic [15:0] m_ifpc = 16'h0000;
  logic        m_valid = 1'b0;
  logic [15:0] m_count = 16'h0000;
  logic [1:0]  m_state = 2'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 16'h0000; m_instr <= Nop; m_ifpc <= 16'h0000;
      m_valid <= 1'b0; m_count <= 16'h0000; m_state <= 2'd0;
    end else if (bus.branch_valid) begin
      m_pc <= bus.branch_target; m_instr <= Nop; m_ifpc <= 16'h0000; m_valid <= 1'b0;
      m_state <= bus.MemConflict ? 2'd1 : 2'd2;
    end else if (bus.MemConflict) begin
      if (!bus.stall_i) begin
        m_instr <= Nop; m_ifpc <= 16'h0000; m_valid <= 1'b0;
      end
      m_state <= 2'd1;
    end else if (bus.stall_i) begin
      m_state <= 2'd0;
    end else begin
      m_instr <= mem(m_pc); m_ifpc <= m_pc; m_valid <= 1'b1;
      m_pc <= m_pc + 16'd4; m_count <= m_count + 16'd1; m_state <= 2'd0;
    end
  end

  always @(negedge clk) begin
    chk("imem_pc", bus.imem_pc, m_pc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_pc", bus.if_id_pc, m_ifpc);
    chk("if_id_valid", {15'd0, bus.if_id_valid}, {15'd0, m_valid});
    chk("fetch_count", bus.fetch_count, m_count);
    chk("fetch_state", {14'd0, bus.fetch_state}, {14'd0, m_state});
  end

  task automatic drive(input logic mc, input logic st, input logic bv, input logic [15:0] bt);
    bus.MemConflict   = mc;
    bus.stall_i       = st;
    bus.branch_valid  = bv;
    bus.branch_target = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct packed {
    logic        mc;
    logic        st;
    logic        bv;
    logic [15:0] bt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    n_chk = 0;
    n_err = 0;
    vecs = '{
      '{1'b0, 1'b1, 1'b0, 16'h0000},  // stall in RUN
      '{1'b0, 1'b0, 1'b1, 16'h0100},  // branch
      '{1'b0, 1'b1, 1'b0, 16'h0000},  // stall while FLUSHED
      '{1'b0, 1'b1, 1'b1, 16'h0200},  // branch beats stall
      '{1'b0, 1'b0, 1'b1, 16'h0300},  // back-to-back branch
      '{1'b0, 1'b0, 1'b0, 16'h0000},
      '{1'b1, 1'b1, 1'b0, 16'h0000},  // conflict with stall holds IF/ID
      '{1'b0, 1'b1, 1'b0, 16'h0000},  // CONFLICT -> RUN under stall
      '{1'b1, 1'b0, 1'b0, 16'h0000},
      '{1'b1, 1'b1, 1'b1, 16'h0500},  // branch beats both
      '{1'b0, 1'b0, 1'b0, 16'h0000},
      '{1'b0, 1'b0, 1'b0, 16'h0000}
    };
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    #1 rst = 1'b0;
    #11 rst = 1'b1;
    #1;
    chk("rst instr", bus.if_id_instr, 16'h0800);
    chk("rst valid", {15'd0, bus.if_id_valid}, 16'd0);
    chk("rst imem_pc", bus.imem_pc, 16'h0000);

    // Sequential fetch from reset; wrap instance runs alongside.
    tick();
    chk("f1 pc", bus.if_id_pc, 16'h0000);
    chk("f1 valid", {15'd0, bus.if_id_valid}, 16'd1);
    chk("wrap pc0", wbus.if_id_pc, 16'hFFFC);
    chk("wrap instr0", wbus.if_id_instr, 16'h3FFF);
    tick();
    chk("wrap pc1", wbus.if_id_pc, 16'h0000);
    chk("wrap imem_pc", wbus.imem_pc, 16'h0004);
    tick();
    tick();
    chk("f4 pc", bus.if_id_pc, 16'h000C);
    chk("f4 instr", bus.if_id_instr, 16'h0003);
    chk("f4 count", bus.fetch_count, 16'd4);
    tick();
    chk("pre-rst imem_pc", bus.imem_pc, 16'h0014);

    // Asynchronous reset mid-stream, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("arst imem_pc", bus.imem_pc, 16'h0000);
    chk("arst instr", bus.if_id_instr, 16'h0800);
    chk("arst count", bus.fetch_count, 16'd0);
    chk("arst state", {14'd0, bus.fetch_state}, 16'd0);
    #2 rst = 1'b1;
    tick();
    chk("restart pc", bus.if_id_pc, 16'h0000);
    tick();

    // Two-cycle memory conflict at pc 0x0008.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("mc1 valid", {15'd0, bus.if_id_valid}, 16'd0);
    chk("mc1 state", {14'd0, bus.fetch_state}, 16'd1);
    tick();
    chk("mc2 instr", bus.if_id_instr, 16'h0800);
    chk("mc2 imem_pc", bus.imem_pc, 16'h0008);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("mc resume pc", bus.if_id_pc, 16'h0008);
    chk("mc resume instr", bus.if_id_instr, 16'h0002);
    chk("mc resume count", bus.fetch_count, 16'd3);

    // Branch to 0x0020 at pc 0x000C.
    drive(1'b0, 1'b0, 1'b1, 16'h0020);
    tick();
    chk("br valid", {15'd0, bus.if_id_valid}, 16'd0);
    chk("br state", {14'd0, bus.fetch_state}, 16'd2);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("br t0", bus.if_id_pc, 16'h0020);
    tick();
    chk("br t1", bus.if_id_pc, 16'h0024);

    // Stall and conflict together: IF/ID and PC held.
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    chk("sc pc", bus.if_id_pc, 16'h0024);
    chk("sc valid", {15'd0, bus.if_id_valid}, 16'd1);
    chk("sc imem_pc", bus.imem_pc, 16'h0028);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("sc resume", bus.if_id_pc, 16'h0028);

    // Branch during a conflict is kept and held until the conflict drops.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h0040);
    tick();
    chk("bc state", {14'd0, bus.fetch_state}, 16'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("bc hold", bus.imem_pc, 16'h0040);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("bc fetch", bus.if_id_pc, 16'h0040);
    chk("bc count", bus.fetch_count, 16'd7);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].mc, vecs[i].st, vecs[i].bv, vecs[i].bt);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
